// File: rtl/lfsr_test_ctrl.sv
// lfsr_test_ctrl: sequencer for the 8-bit LFSR generator/checker self-test.
// It loads a seed, paces the shared valid strobe and waits for checker lock.
// It then soaks, injects corrupted words, confirms unlock and relock, and reports the result.
// Optional run/fail statistics counters are built only when LFSR_CTRL_STATS_EN is defined.
module lfsr_test_ctrl #(
  parameter int unsigned VALID_PERIOD   = 1,
  parameter int unsigned LOCK_TIMEOUT   = 64,
  parameter int unsigned SOAK_LEN       = 32,
  parameter int unsigned INJECT_LEN     = 4,
  parameter int unsigned UNLOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_seed,
  input  logic        i_lock,
  output logic [7:0]  o_gen_seed,
  output logic        o_gen_load,
  output logic        o_valid,
  output logic        o_corrupt,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [2:0]  o_fail_code,
  output logic [7:0]  o_lock_cycles,
  output logic [15:0] o_run_count,
  output logic [15:0] o_fail_count
);

  localparam int unsigned CW  = 8;
  localparam int unsigned FCW = 3;
  localparam int unsigned SW  = 16;

  localparam logic [CW-1:0] DIV_LAST    = CW'(VALID_PERIOD - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SOAK_LAST   = CW'(SOAK_LEN - 1);
  localparam logic [CW-1:0] INJECT_LAST = CW'(INJECT_LEN - 1);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_TIMEOUT - 1);

  localparam logic [FCW-1:0] CODE_PASS     = FCW'(0);
  localparam logic [FCW-1:0] CODE_NO_LOCK  = FCW'(1);
  localparam logic [FCW-1:0] CODE_SOAK     = FCW'(2);
  localparam logic [FCW-1:0] CODE_NO_UNLK  = FCW'(3);
  localparam logic [FCW-1:0] CODE_NO_RELCK = FCW'(4);
  localparam logic [FCW-1:0] CODE_ABORT    = FCW'(5);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACQUIRE, S_SOAK, S_INJECT, S_WAIT_UNLOCK, S_RELOCK, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  div_q, cnt_q, seed_q, lock_cycles_q;
  logic           pass_q;
  logic [FCW-1:0] code_q, code_d;
  logic           active_c, strobe_c, start_c;

  assign active_c = (state_q inside {S_ACQUIRE, S_SOAK, S_INJECT, S_WAIT_UNLOCK, S_RELOCK});
  assign strobe_c = active_c && (div_q == DIV_LAST);
  assign start_c  = (state_q == S_IDLE) && i_start;

  // State register
  always_ff @(posedge clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and completion code; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE:        if (i_start) state_d = S_LOAD;
      S_LOAD:        state_d = S_ACQUIRE;
      S_ACQUIRE: begin
        if (i_lock) state_d = S_SOAK;
        else if (strobe_c && cnt_q == LOCK_LAST) begin
          state_d = S_DONE;
          code_d  = CODE_NO_LOCK;
        end
      end
      S_SOAK: begin
        if (!i_lock) begin
          state_d = S_DONE;
          code_d  = CODE_SOAK;
        end else if (strobe_c && cnt_q == SOAK_LAST) state_d = S_INJECT;
      end
      S_INJECT:      if (strobe_c && cnt_q == INJECT_LAST) state_d = S_WAIT_UNLOCK;
      S_WAIT_UNLOCK: begin
        if (!i_lock) state_d = S_RELOCK;
        else if (strobe_c && cnt_q == UNLOCK_LAST) begin
          state_d = S_DONE;
          code_d  = CODE_NO_UNLK;
        end
      end
      S_RELOCK: begin
        if (i_lock) begin
          state_d = S_DONE;
          code_d  = CODE_PASS;
        end else if (strobe_c && cnt_q == LOCK_LAST) begin
          state_d = S_DONE;
          code_d  = CODE_NO_RELCK;
        end
      end
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    if (i_abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_DONE;
      code_d  = CODE_ABORT;
    end
  end

  // Strobe divider, per-state strobe counter, seed latch and result registers
  always_ff @(posedge clk) begin
    if (i_rst) begin
      div_q         <= '0;
      cnt_q         <= '0;
      seed_q        <= '0;
      lock_cycles_q <= '0;
      pass_q        <= 1'b0;
      code_q        <= CODE_PASS;
    end else begin
      if (state_q == S_LOAD || strobe_c) div_q <= '0;
      else if (active_c)                 div_q <= div_q + CW'(1);

      if (state_d != state_q)                cnt_q <= '0;
      else if (strobe_c && cnt_q != '1)      cnt_q <= cnt_q + CW'(1);

      if (start_c) begin
        seed_q        <= (i_seed == '0) ? CW'(1) : i_seed;
        lock_cycles_q <= '0;
        pass_q        <= 1'b0;
        code_q        <= CODE_PASS;
      end

      if (state_q == S_ACQUIRE && state_d == S_SOAK) lock_cycles_q <= cnt_q;

      if (state_d == S_DONE && state_q != S_DONE) begin
        code_q <= code_d;
        pass_q <= (code_d == CODE_PASS);
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    o_gen_seed    = seed_q;
    o_gen_load    = (state_q == S_LOAD);
    o_valid       = strobe_c;
    o_corrupt     = strobe_c && (state_q == S_INJECT);
    o_busy        = (state_q != S_IDLE);
    o_done        = (state_q == S_DONE);
    o_pass        = pass_q;
    o_fail_code   = code_q;
    o_lock_cycles = lock_cycles_q;
  end

`ifdef LFSR_CTRL_STATS_EN
  logic [SW-1:0] run_cnt_q, fail_cnt_q;

  // Run and failure statistics, advanced on each completion pulse
  always_ff @(posedge clk) begin
    if (i_rst) begin
      run_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      run_cnt_q <= run_cnt_q + SW'(1);
      if (code_q != CODE_PASS) fail_cnt_q <= fail_cnt_q + SW'(1);
    end
  end

  assign o_run_count  = run_cnt_q;
  assign o_fail_count = fail_cnt_q;
`else
  assign o_run_count  = SW'(0);
  assign o_fail_count = SW'(0);
`endif

endmodule

// File: tb/tb_lfsr_test_ctrl.sv
// Directed bench for lfsr_test_ctrl: default instance plus a VALID_PERIOD=3 instance on shared inputs.
module tb_lfsr_test_ctrl;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_abort, i_lock;
  logic [7:0]  i_seed;

  logic [7:0]  o_gen_seed, o_lock_cycles;
  logic        o_gen_load, o_valid, o_corrupt, o_busy, o_done, o_pass;
  logic [2:0]  o_fail_code;
  logic [15:0] o_run_count, o_fail_count;

  logic [7:0]  p3_gen_seed, p3_lock_cycles;
  logic        p3_gen_load, p3_valid, p3_corrupt, p3_busy, p3_done, p3_pass;
  logic [2:0]  p3_fail_code;
  logic [15:0] p3_run_count, p3_fail_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_test_ctrl dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_seed(i_seed),
    .i_lock(i_lock), .o_gen_seed(o_gen_seed), .o_gen_load(o_gen_load), .o_valid(o_valid),
    .o_corrupt(o_corrupt), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_fail_code(o_fail_code), .o_lock_cycles(o_lock_cycles), .o_run_count(o_run_count),
    .o_fail_count(o_fail_count)
  );

  lfsr_test_ctrl #(.VALID_PERIOD(3)) dut_p3 (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_seed(i_seed),
    .i_lock(i_lock), .o_gen_seed(p3_gen_seed), .o_gen_load(p3_gen_load), .o_valid(p3_valid),
    .o_corrupt(p3_corrupt), .o_busy(p3_busy), .o_done(p3_done), .o_pass(p3_pass),
    .o_fail_code(p3_fail_code), .o_lock_cycles(p3_lock_cycles), .o_run_count(p3_run_count),
    .o_fail_count(p3_fail_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  // Returns sampled in the LOAD cycle
  task automatic start_run(input logic [7:0] seed);
    i_seed  = seed;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 1000 && seen < n; k++) begin
      step();
      if (o_valid) seen++;
    end
    if (seen < n) check("wait_strobes_bound", 32'(seen), 32'(n));
  endtask

  task automatic wait_corrupt_end(output int ncorr);
    ncorr = 0;
    for (int k = 0; k < 1000 && !o_corrupt; k++) step();
    for (int k = 0; k < 1000 && o_corrupt; k++) begin
      ncorr++;
      step();
    end
  endtask

  // Counts strobes from the current sample until o_done is seen
  task automatic wait_done(output int strobes);
    strobes = 0;
    for (int k = 0; k < 2000 && !o_done; k++) begin
      if (o_valid) strobes++;
      step();
    end
    check("done_seen", 32'(o_done), 32'd1);
  endtask

  // Full passing run: lock after 7 strobes, unlock 2 strobes after injection, relock 5 later
  task automatic pass_run(input logic [7:0] seed, output int ncorr);
    int st;
    start_run(seed);
    wait_strobes(7);
    step();
    i_lock = 1'b1;
    wait_corrupt_end(ncorr);
    step();
    step();
    i_lock = 1'b0;
    repeat (5) step();
    i_lock = 1'b1;
    wait_done(st);
  endtask

  initial begin
    int ncorr, st;
    logic exp_v;
    i_rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_lock = 1'b0; i_seed = 8'h00;

    // Reset state
    do_reset();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_seed", 32'(o_gen_seed), 32'd0);
    check("rst_pass", 32'(o_pass), 32'd0);
    check("rst_code", 32'(o_fail_code), 32'd0);
    check("rst_lockcyc", 32'(o_lock_cycles), 32'd0);
    check("rst_runcnt", 32'(o_run_count), 32'd0);

    // Full passing run with seed A5
    start_run(8'hA5);
    check("load_pulse", 32'(o_gen_load), 32'd1);
    check("load_seed", 32'(o_gen_seed), 32'hA5);
    check("load_novalid", 32'(o_valid), 32'd0);
    check("load_busy", 32'(o_busy), 32'd1);
    step();
    check("first_strobe", 32'(o_valid), 32'd1);
    wait_strobes(6);
    step();
    i_lock = 1'b1;
    wait_corrupt_end(ncorr);
    check("pass_corrupt_cnt", 32'(ncorr), 32'd4);
    step();
    step();
    i_lock = 1'b0;
    repeat (5) step();
    i_lock = 1'b1;
    wait_done(st);
    check("pass_flag", 32'(o_pass), 32'd1);
    check("pass_code", 32'(o_fail_code), 32'd0);
    check("pass_lockcyc", 32'(o_lock_cycles), 32'd7);
    check("done_novalid", 32'(o_valid), 32'd0);
    step();
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("idle_after_done", 32'(o_busy), 32'd0);
    check("pass_held", 32'(o_pass), 32'd1);
    i_lock = 1'b0;

    // Never locks: timeout after 64 strobes
    start_run(8'h3C);
    check("start_clr_pass", 32'(o_pass), 32'd0);
    check("start_clr_lockcyc", 32'(o_lock_cycles), 32'd0);
    wait_done(st);
    check("nolock_strobes", 32'(st), 32'd64);
    check("nolock_code", 32'(o_fail_code), 32'd1);
    check("nolock_lockcyc", 32'(o_lock_cycles), 32'd0);
    check("nolock_pass", 32'(o_pass), 32'd0);
    step();

    // Lock at strobe 3, lost at soak strobe 10
    start_run(8'h11);
    wait_strobes(3);
    step();
    i_lock = 1'b1;
    wait_strobes(10);
    i_lock = 1'b0;
    wait_done(st);
    check("soak_code", 32'(o_fail_code), 32'd2);
    check("soak_lockcyc", 32'(o_lock_cycles), 32'd3);
    step();

    // Lock never drops after injection: no-unlock after 16 strobes
    start_run(8'h22);
    wait_strobes(1);
    step();
    i_lock = 1'b1;
    wait_corrupt_end(ncorr);
    wait_done(st);
    check("nounlock_strobes", 32'(st), 32'd16);
    check("nounlock_code", 32'(o_fail_code), 32'd3);
    i_lock = 1'b0;
    step();

    // Zero seed substitution and VALID_PERIOD=3 cadence
    do_reset();
    start_run(8'h00);
    check("zseed_a", 32'(o_gen_seed), 32'h01);
    check("zseed_p3", 32'(p3_gen_seed), 32'h01);
    check("p3_load", 32'(p3_gen_load), 32'd1);
    check("p3_valid_j1", 32'(p3_valid), 32'd0);
    for (int j = 2; j <= 10; j++) begin
      step();
      exp_v = (j >= 4) && (((j - 4) % 3) == 0);
      check($sformatf("p3_valid_j%0d", j), 32'(p3_valid), 32'(exp_v));
    end
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("p3_abort_done", 32'(p3_done), 32'd1);
    check("p3_abort_code", 32'(p3_fail_code), 32'd5);
    step();

    // Start ignored while busy, then abort in SOAK
    start_run(8'h5A);
    wait_strobes(2);
    step();
    i_lock = 1'b1;
    repeat (3) step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("busy_start_noload", 32'(o_gen_load), 32'd0);
    check("busy_start_busy", 32'(o_busy), 32'd1);
    check("busy_start_lockcyc", 32'(o_lock_cycles), 32'd2);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_done", 32'(o_done), 32'd1);
    check("abort_code", 32'(o_fail_code), 32'd5);
    check("abort_novalid", 32'(o_valid), 32'd0);
    step();
    check("abort_idle", 32'(o_busy), 32'd0);

    // Reset in the middle of injection
    start_run(8'h77);
    wait_strobes(1);
    step();
    i_lock = 1'b1;
    for (int k = 0; k < 200 && !o_corrupt; k++) step();
    check("inject_reached", 32'(o_corrupt), 32'd1);
    i_rst = 1'b1;
    step();
    check("rst_mid_corrupt", 32'(o_corrupt), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_seed", 32'(o_gen_seed), 32'd0);
    check("rst_mid_lockcyc", 32'(o_lock_cycles), 32'd0);
    i_rst = 1'b0;
    i_lock = 1'b0;
    step();
    check("rst_mid_idle", 32'(o_busy), 32'd0);

    // Statistics: one pass then one fail
    do_reset();
    pass_run(8'h5C, ncorr);
    check("stats_pass_code", 32'(o_fail_code), 32'd0);
    step();
    i_lock = 1'b0;
    start_run(8'h66);
    wait_done(st);
    check("stats_fail_code", 32'(o_fail_code), 32'd1);
    step();
`ifdef LFSR_CTRL_STATS_EN
    check("stats_run", 32'(o_run_count), 32'd2);
    check("stats_fail", 32'(o_fail_count), 32'd1);
`else
    check("stats_run", 32'(o_run_count), 32'd0);
    check("stats_fail", 32'(o_fail_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
